mem_lsu: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM pipeline register. Consumes its integer and CSR write-back fields plus a load/store descriptor.
- Performs data-bus transactions with a req/ack handshake, and does byte-lane steering and load sign/zero extension.
- Raises a pipeline stall while an access is outstanding, then presents the write-back fields to the MEM/WB register.
- Non-memory instructions pass through with zero added latency.

---
 rtl/mem_lsu.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Memory-access stage: data-bus req/ack handshake, byte-lane steering and load
// extension, with a pipeline stall held while an access is outstanding.
module mem_lsu #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int CSR_AW  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_we,
    input  logic              mem_csr_we,
    input  logic [CSR_AW-1:0] mem_csr_waddr,
    input  logic [XLEN-1:0]   mem_csr_wdata,
    input  logic [3:0]        mem_op,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_sdata,
    output logic              d_req,
    output logic              d_we,
    output logic [XLEN-1:0]   d_addr,
    output logic [3:0]        d_be,
    output logic [XLEN-1:0]   d_wdata,
    input  logic              d_ack,
    input  logic [XLEN-1:0]   d_rdata,
    input  logic              d_err,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [XLEN-1:0]   wb_wdata,
    output logic              wb_we,
    output logic              wb_csr_we,
    output logic [CSR_AW-1:0] wb_csr_waddr,
    output logic [XLEN-1:0]   wb_csr_wdata,
    output logic              stall_req,
    output logic              exc_misalign,
    output logic              exc_bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    // sz: 0 byte, 1 half, 2 word
    typedef struct packed {
        logic       ld;
        logic       st;
        logic [1:0] sz;
        logic       uns;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '0;
        case (op)
            4'b0001: begin d.ld = 1'b1; d.sz = 2'd0; end
            4'b0010: begin d.ld = 1'b1; d.sz = 2'd1; end
            4'b0011: begin d.ld = 1'b1; d.sz = 2'd2; end
            4'b0100: begin d.ld = 1'b1; d.sz = 2'd0; d.uns = 1'b1; end
            4'b0101: begin d.ld = 1'b1; d.sz = 2'd1; d.uns = 1'b1; end
            4'b1001: begin d.st = 1'b1; d.sz = 2'd0; end
            4'b1010: begin d.st = 1'b1; d.sz = 2'd1; end
            4'b1011: begin d.st = 1'b1; d.sz = 2'd2; end
            default: ;
        endcase
        return d;
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    dec_t dec_i, dec_q, bdec;
    logic acc_i, mis_i;
    logic [1:0] boff;

    assign dec_i = decode(mem_op);
    assign dec_q = decode(op_q);
    assign acc_i = dec_i.ld | dec_i.st;
    assign mis_i = (dec_i.sz == 2'd1 && mem_addr[0]) || (dec_i.sz == 2'd2 && mem_addr[1:0] != 2'b00);

    // The request cycle steers from live inputs; WAIT steers from the latched descriptor.
    assign bdec = (state_q == S_IDLE) ? dec_i : dec_q;
    assign boff = (state_q == S_IDLE) ? mem_addr[1:0] : off_q;

    logic [3:0]      be;
    logic [XLEN-1:0] wd;
    always_comb begin
        case (bdec.sz)
            2'd0:    begin be = 4'b0001 << boff; wd = {4{mem_sdata[7:0]}};  end
            2'd1:    begin be = 4'b0011 << boff; wd = {2{mem_sdata[15:0]}}; end
            default: begin be = 4'b1111;         wd = mem_sdata;            end
        endcase
    end

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;
    always_comb begin
        ld_byte = rdata_q[{off_q, 3'b000} +: 8];
        ld_half = rdata_q[{off_q[1], 4'b0000} +: 16];
        case (dec_q.sz)
            2'd0:    ld_ext = {{(XLEN-8){~dec_q.uns & ld_byte[7]}}, ld_byte};
            2'd1:    ld_ext = {{(XLEN-16){~dec_q.uns & ld_half[15]}}, ld_half};
            default: ld_ext = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (acc_i && !mis_i) begin
                    op_d    = mem_op;
                    off_d   = mem_addr[1:0];
                    err_d   = d_ack & d_err;
                    rdata_d = d_ack ? d_rdata : rdata_q;
                    state_d = d_ack ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (d_ack) begin
                    rdata_d = d_rdata;
                    err_d   = d_err;
                    state_d = S_DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 4'd0;
            off_q   <= 2'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        wb_waddr     = mem_waddr;
        wb_wdata     = mem_wdata;
        wb_we        = mem_we;
        wb_csr_we    = mem_csr_we;
        wb_csr_waddr = mem_csr_waddr;
        wb_csr_wdata = mem_csr_wdata;
        d_req        = 1'b0;
        d_we         = 1'b0;
        d_addr       = '0;
        d_be         = 4'b0000;
        d_wdata      = '0;
        stall_req    = 1'b0;
        exc_misalign = 1'b0;
        exc_bus_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_i && mis_i) begin
                    exc_misalign = 1'b1;
                    wb_we        = 1'b0;
                    wb_csr_we    = 1'b0;
                end else if (acc_i) begin
                    d_req     = 1'b1;
                    stall_req = 1'b1;
                end
            end
            S_WAIT: begin
                d_req     = 1'b1;
                stall_req = 1'b1;
            end
            default: begin
                if (dec_q.ld) wb_wdata = ld_ext;
                if (err_q) begin
                    exc_bus_err = 1'b1;
                    wb_we       = 1'b0;
                    wb_csr_we   = 1'b0;
                end
            end
        endcase
        if (d_req) begin
            d_we    = bdec.st;
            d_addr  = {mem_addr[XLEN-1:2], 2'b00};
            d_be    = be;
            d_wdata = wd;
        end
        if (rst) begin
            wb_waddr     = '0;
            wb_wdata     = '0;
            wb_we        = 1'b0;
            wb_csr_we    = 1'b0;
            wb_csr_waddr = '0;
            wb_csr_wdata = '0;
            d_req        = 1'b0;
            d_we         = 1'b0;
            d_addr       = '0;
            d_be         = 4'b0000;
            d_wdata      = '0;
            stall_req    = 1'b0;
            exc_misalign = 1'b0;
            exc_bus_err  = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized checks of mem_lsu against a byte-level reference model.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_waddr, wb_waddr;
    logic [31:0] mem_wdata, wb_wdata, mem_csr_wdata, wb_csr_wdata;
    logic        mem_we, wb_we, mem_csr_we, wb_csr_we;
    logic [11:0] mem_csr_waddr, wb_csr_waddr;
    logic [3:0]  mem_op, d_be;
    logic [31:0] mem_addr, mem_sdata, d_addr, d_wdata, d_rdata;
    logic        d_req, d_we, d_ack, d_err, stall_req, exc_misalign, exc_bus_err;

    int checks = 0;
    int failures = 0;
    logic [3:0] op_tab [12];

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_csr_we(mem_csr_we), .mem_csr_waddr(mem_csr_waddr), .mem_csr_wdata(mem_csr_wdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_we(wb_we),
        .wb_csr_we(wb_csr_we), .wb_csr_waddr(wb_csr_waddr), .wb_csr_wdata(wb_csr_wdata),
        .stall_req(stall_req), .exc_misalign(exc_misalign), .exc_bus_err(exc_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for non-memory codes.
    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'h1, 4'h4, 4'h9: return 1;
            4'h2, 4'h5, 4'hA: return 2;
            4'h3, 4'hB:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit is_load(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    endfunction

    function automatic bit is_misaligned(input logic [3:0] op, input logic [31:0] addr);
        int n = nbytes(op);
        return n > 1 && (int'(addr[1:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
        logic [3:0] be = 4'b0000;
        int off = int'(addr[1:0]);
        int n = nbytes(op);
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sdata);
        logic [31:0] w;
        int n = nbytes(op);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sdata[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int n = nbytes(op);
        logic [31:0] v = rdata >> (8 * int'(addr[1:0]));
        logic [31:0] mask;
        if (n == 4) return v;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if ((op == 4'h1 || op == 4'h2) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fields();
        mem_waddr     = 5'($urandom);
        mem_wdata     = $urandom;
        mem_we        = 1'($urandom);
        mem_csr_we    = 1'($urandom);
        mem_csr_waddr = 12'($urandom);
        mem_csr_wdata = $urandom;
        mem_sdata     = $urandom;
    endtask

    task automatic run_none(input logic [3:0] op);
        load_fields();
        mem_op = op;
        mem_addr = $urandom;
        d_ack = 1'b0;
        #1;
        chk("none_wb_waddr", wb_waddr, mem_waddr);
        chk("none_wb_wdata", wb_wdata, mem_wdata);
        chk("none_wb_we", wb_we, mem_we);
        chk("none_wb_csr_we", wb_csr_we, mem_csr_we);
        chk("none_wb_csr_waddr", wb_csr_waddr, mem_csr_waddr);
        chk("none_wb_csr_wdata", wb_csr_wdata, mem_csr_wdata);
        chk("none_stall", stall_req, 0);
        chk("none_d_req", d_req, 0);
        tick();
    endtask

    task automatic run_misalign(input logic [3:0] op, input logic [31:0] addr);
        load_fields();
        mem_we = 1'b1;
        mem_csr_we = 1'b1;
        mem_op = op;
        mem_addr = addr;
        d_ack = 1'b0;
        #1;
        chk("mis_exc", exc_misalign, 1);
        chk("mis_d_req", d_req, 0);
        chk("mis_stall", stall_req, 0);
        chk("mis_wb_we", wb_we, 0);
        chk("mis_wb_csr_we", wb_csr_we, 0);
        tick();
        mem_op = 4'h0;
        #1;
        chk("mis_pulse_end", exc_misalign, 0);
        chk("mis_idle_wb_we", wb_we, mem_we);
        tick();
    endtask

    // delay < 0 means the bus never acknowledges.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic err, input int delay);
        int stalls = 0;
        bit eff_err = (delay < 0) ? 1'b1 : err;
        load_fields();
        mem_op = op;
        mem_addr = addr;
        mem_sdata = sdata;
        for (int c = 0; c < 300; c++) begin
            d_ack   = (c == delay);
            d_rdata = (c == delay) ? rdata : $urandom;
            d_err   = (c == delay) ? err : 1'($urandom);
            #1;
            if (!stall_req) break;
            stalls++;
            chk("acc_d_req", d_req, 1);
            chk("acc_d_we", d_we, !is_load(op));
            chk("acc_d_addr", d_addr, addr & ~32'h3);
            chk("acc_d_be", d_be, m_be(op, addr));
            if (!is_load(op)) chk("acc_d_wdata", d_wdata, m_wdata(op, sdata));
            tick();
        end
        d_ack = 1'b0;
        chk("acc_stall_cycles", stalls, (delay < 0) ? 256 : delay + 1);
        chk("done_d_req", d_req, 0);
        chk("done_wb_wdata", wb_wdata, is_load(op) ? m_load(op, addr, rdata) : mem_wdata);
        chk("done_wb_waddr", wb_waddr, mem_waddr);
        chk("done_wb_we", wb_we, eff_err ? 1'b0 : mem_we);
        chk("done_wb_csr_we", wb_csr_we, eff_err ? 1'b0 : mem_csr_we);
        chk("done_wb_csr_wdata", wb_csr_wdata, mem_csr_wdata);
        chk("done_exc_bus_err", exc_bus_err, eff_err);
        chk("done_exc_misalign", exc_misalign, 0);
        tick();
        mem_op = 4'h0;
        #1;
        chk("post_exc_bus_err", exc_bus_err, 0);
        chk("post_stall", stall_req, 0);
        tick();
    endtask

    initial begin
        op_tab = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA, 4'hB, 4'h0, 4'h6, 4'h7, 4'hF};
        rst = 1'b1;
        d_ack = 1'b0;
        d_err = 1'b0;
        d_rdata = '0;
        load_fields();
        mem_we = 1'b1;
        mem_csr_we = 1'b1;
        mem_op = 4'h3;
        mem_addr = 32'h40;
        tick();
        tick();
        chk("rst_d_req", d_req, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_wdata", wb_wdata, 0);
        chk("rst_wb_csr_we", wb_csr_we, 0);
        rst = 1'b0;

        // op none pass-through
        load_fields();
        mem_op = 4'h0; mem_wdata = 32'h1234; mem_we = 1'b1; mem_waddr = 5'd5;
        #1;
        chk("tp_none_wdata", wb_wdata, 32'h1234);
        chk("tp_none_we", wb_we, 1);
        chk("tp_none_waddr", wb_waddr, 5);
        chk("tp_none_stall", stall_req, 0);
        chk("tp_none_d_req", d_req, 0);
        tick();

        run_access(4'h1, 32'h103, 32'h0, 32'h80FF_FF00, 1'b0, 2);   // LB, expect 0xFFFFFF80
        run_access(4'hA, 32'h202, 32'hAAAA_BEEF, 32'h0, 1'b0, 0);   // SH, ack in request cycle
        run_misalign(4'h3, 32'h301);
        run_access(4'h3, 32'h400, 32'h0, 32'h0, 1'b0, -1);         // LW timeout
        run_access(4'h3, 32'h404, 32'h0, 32'hDEAD_BEEF, 1'b1, 1);  // LW bus error

        // rst in the 2nd WAIT cycle abandons the access
        load_fields();
        mem_op = 4'h1; mem_addr = 32'h0; d_ack = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_d_req", d_req, 0);
        chk("rstw_stall", stall_req, 0);
        tick();
        rst = 1'b0;
        mem_op = 4'h0; mem_we = 1'b0; mem_csr_we = 1'b0;
        d_ack = 1'b1; d_err = 1'b1; d_rdata = $urandom;
        #1;
        chk("late_ack_d_req", d_req, 0);
        chk("late_ack_stall", stall_req, 0);
        chk("late_ack_exc", exc_bus_err, 0);
        tick();
        d_ack = 1'b0;
        #1;
        chk("late_ack_exc2", exc_bus_err, 0);
        chk("late_ack_wb_we", wb_we, 0);
        tick();
        run_access(4'h4, 32'h0, 32'h0, 32'h0000_0080, 1'b0, 0);    // LBU -> 0x80

        for (int it = 0; it < 30; it++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            int n;
            op = op_tab[$urandom_range(0, 11)];
            addr = $urandom;
            n = nbytes(op);
            if (n > 1 && $urandom_range(0, 2) != 0) addr = addr & ~32'(n - 1);
            if (n == 0) run_none(op);
            else if (is_misaligned(op, addr)) run_misalign(op, addr);
            else run_access(op, addr, $urandom, $urandom, ($urandom_range(0, 5) == 0), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
